// File: rtl/ndro_pulse_sched.sv
// ndro_pulse_sched: schedules SET / RESET / READ pulses onto an NDRO cell for
// two requesting ports. It enforces the minimum spacing between pulses that
// the cell needs, shares the cell round-robin between the ports, and returns
// read data through a fixed-latency pipeline.
// Optional build: define NDRO_SCHED_QCHECK_EN to check q_in on every read and
// return the observed toggle as rd_data.
//
// Handshake: pX_ready is combinational and high only for the port granted this
// cycle. A command issues when pX_valid & pX_ready at a rising clk edge. A
// waiting requester holds valid; its op may change and is re-evaluated each cycle.
module ndro_pulse_sched #(
    parameter int unsigned GAP_AB   = 1,
    parameter int unsigned GAP_BA   = 5,
    parameter int unsigned GAP_CC   = 10,
    parameter int unsigned READ_LAT = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       p0_valid,
    input  logic [1:0] p0_op,
    output logic       p0_ready,
    input  logic       p1_valid,
    input  logic [1:0] p1_op,
    output logic       p1_ready,
    output logic       cell_a,
    output logic       cell_b,
    output logic       cell_clk,
    input  logic       q_in,
    output logic       rd_valid,
    output logic       rd_data,
    output logic       rd_port,
    output logic       err
);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    localparam int CW = 16;
    // A command may issue GAP cycles after the guarding issue. The counter is
    // loaded with GAP-1 so that "counter != 0" blocks exactly the cycles in
    // between (GAP=0 and GAP=1 both leave the next cycle unblocked).
    localparam logic [CW-1:0] AB_LOAD = (GAP_AB > 0) ? CW'(GAP_AB - 1) : '0;
    localparam logic [CW-1:0] BA_LOAD = (GAP_BA > 0) ? CW'(GAP_BA - 1) : '0;
    localparam logic [CW-1:0] CC_LOAD = (GAP_CC > 0) ? CW'(GAP_CC - 1) : '0;
    localparam int L = (READ_LAT < 1) ? 1 : int'(READ_LAT);

    // Architectural state
    logic [CW-1:0] ctr_ab_q, ctr_ab_d;
    logic [CW-1:0] ctr_ba_q, ctr_ba_d;
    logic [CW-1:0] ctr_cc_q, ctr_cc_d;
    logic          shadow_q, shadow_d;
    logic          ptr_q, ptr_d;
    logic          pend_a_q, pend_a_d;
    logic          pend_b_q, pend_b_d;
    logic          pend_c_q, pend_c_d;
    logic          cell_a_q, cell_a_d;
    logic          cell_b_q, cell_b_d;
    logic          cell_clk_q, cell_clk_d;
    logic [L-1:0]  pv_q, pv_d;       // read in flight at each pipeline stage
    logic [L-1:0]  psh_q, psh_d;     // shadow captured at read issue
    logic [L-1:0]  pport_q, pport_d; // issuing port of each read
    logic          rd_valid_q, rd_valid_d;
    logic          rd_data_q, rd_data_d;
    logic          rd_port_q, rd_port_d;
    logic          err_q, err_d;

`ifdef NDRO_SCHED_QCHECK_EN
    logic          q_prev_q, q_prev_d;
    logic [L-1:0]  pseen_q, pseen_d; // q_in toggle seen since read issue
    logic          q_tog;
    logic          seen_final;
`else
    logic          unused_q_in;
    assign unused_q_in = q_in;
`endif

    // Arbitration signals
    logic       blk0, blk1;
    logic       elig0, elig1;
    logic       gnt0, gnt1;
    logic       iss;
    logic [1:0] iss_op;

    // Eligibility and round-robin grant; at most one port issues per cycle
    always_comb begin
        blk0  = ((p0_op == OP_SET) && (ctr_ba_q != '0)) ||
                ((p0_op == OP_RST) && (ctr_ab_q != '0)) ||
                ((p0_op == OP_RD)  && (ctr_cc_q != '0));
        blk1  = ((p1_op == OP_SET) && (ctr_ba_q != '0)) ||
                ((p1_op == OP_RST) && (ctr_ab_q != '0)) ||
                ((p1_op == OP_RD)  && (ctr_cc_q != '0));
        elig0 = rst_n && p0_valid && !blk0;
        elig1 = rst_n && p1_valid && !blk1;
        gnt0  = elig0 && (!elig1 || !ptr_q);
        gnt1  = elig1 && (!elig0 ||  ptr_q);
        iss   = gnt0 || gnt1;
        iss_op = gnt1 ? p1_op : p0_op;
    end

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

`ifdef NDRO_SCHED_QCHECK_EN
    // Each edge of q_in is one cell output pulse
    always_comb begin
        q_tog      = q_in ^ q_prev_q;
        seen_final = pseen_q[L-1] | q_tog;
    end
`endif

    // Next-state: guards, shadow, pointer, pulse lines, read pipeline, error
    always_comb begin
        ctr_ab_d = (ctr_ab_q != '0) ? ctr_ab_q - 1'b1 : '0;
        ctr_ba_d = (ctr_ba_q != '0) ? ctr_ba_q - 1'b1 : '0;
        ctr_cc_d = (ctr_cc_q != '0) ? ctr_cc_q - 1'b1 : '0;
        shadow_d = shadow_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        pend_a_d = iss && (iss_op == OP_SET);
        pend_b_d = iss && (iss_op == OP_RST);
        pend_c_d = iss && (iss_op == OP_RD);

        if (iss) begin
            // Moves away from the port just served
            ptr_d = gnt0;
            unique case (iss_op)
                OP_SET: begin
                    ctr_ab_d = AB_LOAD;
                    shadow_d = 1'b1;
                end
                OP_RST: begin
                    ctr_ba_d = BA_LOAD;
                    shadow_d = 1'b0;
                end
                OP_RD: begin
                    if (shadow_q) ctr_cc_d = CC_LOAD;
                end
                OP_NOP: err_d = 1'b1;
                default: ;
            endcase
        end

        // Pulses leave one edge after issue
        cell_a_d   = cell_a_q   ^ pend_a_q;
        cell_b_d   = cell_b_q   ^ pend_b_q;
        cell_clk_d = cell_clk_q ^ pend_c_q;

        pv_d[0]    = iss && (iss_op == OP_RD);
        psh_d[0]   = shadow_q;
        pport_d[0] = gnt1;
        for (int k = 1; k < L; k++) begin
            pv_d[k]    = pv_q[k-1];
            psh_d[k]   = psh_q[k-1];
            pport_d[k] = pport_q[k-1];
        end

        rd_valid_d = pv_q[L-1];
        rd_port_d  = pport_q[L-1];
`ifdef NDRO_SCHED_QCHECK_EN
        q_prev_d   = q_in;
        pseen_d[0] = 1'b0;
        for (int k = 1; k < L; k++) begin
            pseen_d[k] = pseen_q[k-1] | q_tog;
        end
        rd_data_d = seen_final;
        if (pv_q[L-1] && (seen_final != psh_q[L-1])) err_d = 1'b1;
`else
        rd_data_d = psh_q[L-1];
`endif
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_ab_q   <= '0;
            ctr_ba_q   <= '0;
            ctr_cc_q   <= '0;
            shadow_q   <= 1'b0;
            ptr_q      <= 1'b0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            pend_c_q   <= 1'b0;
            cell_a_q   <= 1'b0;
            cell_b_q   <= 1'b0;
            cell_clk_q <= 1'b0;
            pv_q       <= '0;
            psh_q      <= '0;
            pport_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 1'b0;
            rd_port_q  <= 1'b0;
            err_q      <= 1'b0;
`ifdef NDRO_SCHED_QCHECK_EN
            q_prev_q   <= 1'b0;
            pseen_q    <= '0;
`endif
        end else begin
            ctr_ab_q   <= ctr_ab_d;
            ctr_ba_q   <= ctr_ba_d;
            ctr_cc_q   <= ctr_cc_d;
            shadow_q   <= shadow_d;
            ptr_q      <= ptr_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            pend_c_q   <= pend_c_d;
            cell_a_q   <= cell_a_d;
            cell_b_q   <= cell_b_d;
            cell_clk_q <= cell_clk_d;
            pv_q       <= pv_d;
            psh_q      <= psh_d;
            pport_q    <= pport_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_port_q  <= rd_port_d;
            err_q      <= err_d;
`ifdef NDRO_SCHED_QCHECK_EN
            q_prev_q   <= q_prev_d;
            pseen_q    <= pseen_d;
`endif
        end
    end

    assign cell_a   = cell_a_q;
    assign cell_b   = cell_b_q;
    assign cell_clk = cell_clk_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_port  = rd_port_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ndro_pulse_sched.sv
// Directed bench for ndro_pulse_sched with default parameters
// (GAP_AB=1, GAP_BA=5, GAP_CC=10, READ_LAT=9).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_ndro_pulse_sched;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       p0_valid, p1_valid;
    logic [1:0] p0_op, p1_op;
    logic       p0_ready, p1_ready;
    logic       cell_a, cell_b, cell_clk;
    logic       q_in;
    logic       rd_valid, rd_data, rd_port;
    logic       err;

    int n_total = 0;
    int n_bad   = 0;

    ndro_pulse_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0_valid (p0_valid),
        .p0_op    (p0_op),
        .p0_ready (p0_ready),
        .p1_valid (p1_valid),
        .p1_op    (p1_op),
        .p1_ready (p1_ready),
        .cell_a   (cell_a),
        .cell_b   (cell_b),
        .cell_clk (cell_clk),
        .q_in     (q_in),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_port  (rd_port),
        .err      (err)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        p0_op    = OP_NOP;
        p1_op    = OP_NOP;
        q_in     = 1'b0;
    endtask

    // Leaves the bench 1 ns after an edge with rst_n high; the next edge is
    // the first one out of reset.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int seen;
        idle_inputs();
        rst_n = 1'b1;
        #2;

        // ---- reset state ----
        do_reset();
        check("rst_outs", {25'd0, cell_a, cell_b, cell_clk, rd_valid, rd_data, rd_port, err}, 32'd0);
        check("rst_ready", {30'd0, p0_ready, p1_ready}, 32'd0);

        // ---- SET, READ, immediate second READ ----
        p0_valid = 1'b1;
        p0_op    = OP_SET;
        #1;
        check("t1_set_ready", {31'd0, p0_ready}, 32'd1);
        step();                                   // SET issues at E0
        check("t1_cell_a_e0", {31'd0, cell_a}, 32'd0);
        p0_op = OP_RD;
        #1;
        check("t1_rd_ready", {31'd0, p0_ready}, 32'd1);
        step();                                   // READ issues at E1
        check("t1_cell_a_e1", {31'd0, cell_a}, 32'd1);
        check("t1_cell_clk_e1", {31'd0, cell_clk}, 32'd0);
        check("t1_rd2_ready_e1", {31'd0, p0_ready}, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            step();                               // now after edge E1+i
            if (i == 1) check("t1_cell_clk_e2", {31'd0, cell_clk}, 32'd1);
            if (i == 8) check("t1_rdv_early", {31'd0, rd_valid}, 32'd0);
            if (i == 9) begin
                check("t1_rdv", {31'd0, rd_valid}, 32'd1);
                check("t1_rd_data", {31'd0, rd_data}, 32'd1);
                check("t1_rd_port", {31'd0, rd_port}, 32'd0);
            end
            if (i == 10) check("t1_rdv_once", {31'd0, rd_valid}, 32'd0);
            check($sformatf("t1_rd2_ready_%0d", i), {31'd0, p0_ready}, {31'd0, i == 9});
        end
        p0_valid = 1'b0;

        // ---- SET -> RESET -> SET spacing ----
        do_reset();
        p0_valid = 1'b1;
        p0_op    = OP_SET;
        step();                                   // SET at E0
        p0_op = OP_RST;
        #1;
        check("t2_rst_ready", {31'd0, p0_ready}, 32'd1);
        step();                                   // RESET at E1
        check("t2_cell_a", {31'd0, cell_a}, 32'd1);
        p0_op = OP_SET;
        #1;
        n = 0;
        while (!p0_ready && n < 30) begin
            step();
            n++;
        end
        check("t2_set_wait", n, 32'd4);           // issues at E6
        step();
        p0_valid = 1'b0;
        step();
        check("t2_cell_a_back", {31'd0, cell_a}, 32'd0);
        check("t2_cell_b", {31'd0, cell_b}, 32'd1);
        check("t2_err", {31'd0, err}, 32'd0);

        // ---- two ports reading with shadow=0 alternate ----
        do_reset();
        p0_valid = 1'b1;
        p0_op    = OP_RD;
        p1_valid = 1'b1;
        p1_op    = OP_RD;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("t3_gnt_%0d", g), {30'd0, p0_ready, p1_ready},
                  (g % 2 == 0) ? 32'd2 : 32'd1);
            step();
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        repeat (6) step();                        // after E8
        check("t3_rdv_early", {31'd0, rd_valid}, 32'd0);
        step();
        check("t3_rd0", {29'd0, rd_valid, rd_port, rd_data}, 32'b100);
        check("t3_cell_clk", {31'd0, cell_clk}, 32'd1);
        step();
        check("t3_rd1", {29'd0, rd_valid, rd_port, rd_data}, 32'b110);
        step();
        check("t3_rd2", {29'd0, rd_valid, rd_port, rd_data}, 32'b100);
        step();
        check("t3_rd_end", {31'd0, rd_valid}, 32'd0);

        // ---- blocked p0 SET lets p1 READ through ----
        do_reset();
        p1_valid = 1'b1;
        p1_op    = OP_RST;
        #1;
        check("t4_rst_ready", {31'd0, p1_ready}, 32'd1);
        step();                                   // RESET at E0, pointer to p0
        p0_valid = 1'b1;
        p0_op    = OP_SET;
        p1_op    = OP_RD;
        #1;
        check("t4_gnt", {30'd0, p0_ready, p1_ready}, 32'd1);
        step();                                   // p1 READ at E1
        p1_valid = 1'b0;
        #1;
        n = 0;
        while (!p0_ready && n < 30) begin
            step();
            n++;
        end
        check("t4_set_wait", n, 32'd3);           // issues at E5
        step();
        p0_valid = 1'b0;
        repeat (5) step();                        // after E10
        check("t4_rd", {29'd0, rd_valid, rd_port, rd_data}, 32'b110);

        // ---- reserved op ----
        do_reset();
        p1_valid = 1'b1;
        p1_op    = OP_NOP;
        #1;
        check("t5_nop_ready", {31'd0, p1_ready}, 32'd1);
        step();
        p1_valid = 1'b0;
        check("t5_err", {31'd0, err}, 32'd1);
        step();
        check("t5_no_pulse", {29'd0, cell_a, cell_b, cell_clk}, 32'd0);

        // ---- reset with a read in flight ----
        do_reset();
        p0_valid = 1'b1;
        p0_op    = OP_SET;
        step();
        p0_op = OP_RD;
        step();                                   // READ at E1
        p0_valid = 1'b0;
        repeat (3) step();
        check("t6_pre_rst", {30'd0, cell_a, cell_clk}, 32'd3);
        rst_n    = 1'b0;
        p0_valid = 1'b1;
        p0_op    = OP_RST;
        #1;
        check("t6_async_clr", {24'd0, cell_a, cell_b, cell_clk, rd_valid, rd_data, rd_port, err, p0_ready}, 32'd0);
        step();
        step();
        p0_valid = 1'b0;
        rst_n    = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rd_valid) seen++;
        end
        check("t6_no_rdv", seen, 32'd0);

`ifdef NDRO_SCHED_QCHECK_EN
        // ---- shadow=1 read with q_in static ----
        do_reset();
        p0_valid = 1'b1;
        p0_op    = OP_SET;
        step();
        p0_op = OP_RD;
        step();                                   // READ at E1
        p0_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 8) check("t7_err_early", {31'd0, err}, 32'd0);
        end
        check("t7_qc", {29'd0, rd_valid, rd_data, err}, 32'b101);
`else
        // ---- q_in ignored: shadow=0 read while q_in toggles ----
        do_reset();
        p0_valid = 1'b1;
        p0_op    = OP_RD;
        step();                                   // READ at E0
        p0_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            q_in = ~q_in;
            step();
        end
        check("t7_qign", {29'd0, rd_valid, rd_data, err}, 32'b100);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
